// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM controller: mode
// encodings and the channel-select width helper.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // Select-bus width for n channels, never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Two-flop button sampler with rising-edge detect, clocked by a shared tick.
// Ports: clk, rst, tick (sample strobe), btn (raw), press (one-cycle pulse).
module pwm_btn_debounce
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic press
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else if (tick) begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Fires once when the sampled level first goes high.
    assign press = tick & s1 & ~s2;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// N-channel PWM with button-adjusted, shadowed duties and edge/center mode.
// Ports: clk, rst, inc_btn, dec_btn, ch_sel, mode -> pwm_out, duty_flat,
// period_start.
module pwm_multi_ctrl
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int PERIOD   = 100,
    parameter int STEP     = 10,
    parameter int DUTY_RST = 50,
    parameter int DEB_DIV  = 250000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inc_btn,
    input  logic                        dec_btn,
    input  logic [sel_w(CHANNELS)-1:0]  ch_sel,
    input  logic                        mode,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic [CHANNELS*CNT_W-1:0]   duty_flat,
    output logic                        period_start
);

    localparam int SEL_W = sel_w(CHANNELS);
    localparam int PRE_W = $clog2(DEB_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(DEB_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DUTY_INIT = CNT_W'(DUTY_RST);
    localparam logic [CNT_W:0]   PER_X     = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_X    = (CNT_W + 1)'(STEP);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] s;
        s = {1'b0, d} + STEP_X;
        return (s > PER_X) ? PER_X[CNT_W-1:0] : s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] s;
        s = {1'b0, d} - STEP_X;
        return ({1'b0, d} < STEP_X) ? '0 : s[CNT_W-1:0];
    endfunction

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             inc_press;
    logic             dec_press;

    assign tick = (pre == PRE_MAX);

    always_ff @(posedge clk) begin
        if (rst || tick) pre <= '0;
        else             pre <= pre + 1'b1;
    end

    pwm_btn_debounce u_inc (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (inc_btn),
        .press (inc_press)
    );

    pwm_btn_debounce u_dec (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (dec_btn),
        .press (dec_press)
    );

    // Out-of-range selects match no channel and are dropped.
    logic [CNT_W-1:0] shadow [CHANNELS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) shadow[i] <= DUTY_INIT;
        end else if (inc_press ^ dec_press) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_sel == SEL_W'(i))
                    shadow[i] <= inc_press ? sat_inc(shadow[i])
                                           : sat_dec(shadow[i]);
            end
        end
    end

    logic [CNT_W-1:0] cnt;
    logic             down;
    logic             mode_active;

    assign period_start = ~rst & (cnt == '0) & ~down;

    // Center mode holds each endpoint one extra cycle while turning round.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            down        <= 1'b0;
            mode_active <= MODE_EDGE;
        end else begin
            if (period_start) mode_active <= mode;
            if (down) begin
                if (cnt == '0) down <= 1'b0;
                else           cnt  <= cnt - 1'b1;
            end else if (cnt == CNT_MAX) begin
                if (mode_active == MODE_CENTER) down <= 1'b1;
                else                            cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Comparing against the incoming duty on the boundary cycle keeps the
    // first slot of a new period consistent with the rest of it.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] act;
        logic [CNT_W-1:0] duty_next;
        logic             pwm_q;

        assign duty_next = period_start ? shadow[g] : act;

        always_ff @(posedge clk) begin
            if (rst) begin
                act   <= DUTY_INIT;
                pwm_q <= 1'b0;
            end else begin
                act   <= duty_next;
                pwm_q <= (cnt < duty_next);
            end
        end

        assign pwm_out[g]                 = pwm_q;
        assign duty_flat[g*CNT_W +: CNT_W] = act;
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Self-checking bench for pwm_multi_ctrl (3 channels, period 10, step 3).
// Expected streams and duties are queued when stimulus is applied.
module tb_pwm_multi_ctrl;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int P  = 10;
    localparam int ST = 3;
    localparam int DR = 5;
    localparam int DD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inc_btn = 1'b0;
    logic          dec_btn = 1'b0;
    logic [1:0]    ch_sel = 2'd0;
    logic          mode = 1'b0;
    logic [CH-1:0] pwm_out;
    logic [CH*W-1:0] duty_flat;
    logic          period_start;

    int checks = 0;
    int errors = 0;

    logic [CH:0] exp_q [$];
    int          duty_q [$];

    pwm_multi_ctrl #(
        .CHANNELS (CH),
        .CNT_W    (W),
        .PERIOD   (P),
        .STEP     (ST),
        .DUTY_RST (DR),
        .DEB_DIV  (DD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inc_btn      (inc_btn),
        .dec_btn      (dec_btn),
        .ch_sel       (ch_sel),
        .mode         (mode),
        .pwm_out      (pwm_out),
        .duty_flat    (duty_flat),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int duty_of(input int c);
        return int'(duty_flat[c*W +: W]);
    endfunction

    function automatic int cc(input int x);
        int r;
        r = x % (2 * P);
        return (r < P) ? r : 2 * P - 1 - r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_ps();
        int n;
        n = 0;
        step();
        while (period_start !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (period_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_ps: period_start=%b want 1", period_start);
        end
    endtask

    task automatic press(input logic i, input logic d, input int hold);
        inc_btn = i;
        dec_btn = d;
        repeat (hold) step();
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        repeat (8) step();
    endtask

    task automatic push_edge(input int d0, input int d1, input int d2,
                             input int n);
        logic [CH:0] e;
        for (int k = 1; k <= n; k++) begin
            e[CH] = (k % P == 0);
            e[0]  = ((k - 1) % P) < d0;
            e[1]  = ((k - 1) % P) < d1;
            e[2]  = ((k - 1) % P) < d2;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_stream(input string name);
        logic [CH:0] e;
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            k++;
            checks++;
            if ({period_start, pwm_out} !== e) begin
                errors++;
                $display("FAIL %s k=%0d: {ps,pwm}=%b want %b",
                         name, k, {period_start, pwm_out}, e);
            end
        end
    endtask

    task automatic check_duties(input string name);
        int e;
        for (int c = 0; c < CH; c++) begin
            e = duty_q.pop_front();
            checks++;
            if (duty_of(c) !== e) begin
                errors++;
                $display("FAIL %s ch%0d: duty=%0d want %0d",
                         name, c, duty_of(c), e);
            end
        end
    endtask

    task automatic test_reset();
        mode = 1'b0;
        do_reset();
        checks++;
        if (period_start !== 1'b1 || pwm_out !== '0) begin
            errors++;
            $display("FAIL reset_state: ps=%b pwm=%b want 1 000",
                     period_start, pwm_out);
        end
        duty_q.push_back(DR);
        duty_q.push_back(DR);
        duty_q.push_back(DR);
        check_duties("reset_duty");
        push_edge(DR, DR, DR, 30);
        check_stream("reset_pattern");
    endtask

    task automatic test_saturate();
        int m;
        m = DR;
        ch_sel = 2'd2;
        repeat (6) begin
            press(1'b1, 1'b0, 8);
            m = (m + ST > P) ? P : m + ST;
            duty_q.push_back(DR);
            duty_q.push_back(DR);
            duty_q.push_back(m);
            wait_ps();
            step();
            check_duties("sat_duty");
        end
        for (int k = 0; k < 25; k++) begin
            step();
            checks++;
            if (pwm_out[2] !== 1'b1) begin
                errors++;
                $display("FAIL sat_high k=%0d: pwm2=%b want 1", k, pwm_out[2]);
            end
        end
    endtask

    task automatic test_hold();
        ch_sel = 2'd0;
        press(1'b1, 1'b0, 20 * DD);
        duty_q.push_back(DR + ST);
        duty_q.push_back(DR);
        duty_q.push_back(P);
        wait_ps();
        step();
        check_duties("hold_once");
        press(1'b1, 1'b1, 8);
        duty_q.push_back(DR + ST);
        duty_q.push_back(DR);
        duty_q.push_back(P);
        wait_ps();
        step();
        check_duties("inc_dec_same");
        ch_sel = 2'd3;
        press(1'b1, 1'b0, 8);
        duty_q.push_back(DR + ST);
        duty_q.push_back(DR);
        duty_q.push_back(P);
        wait_ps();
        step();
        check_duties("sel_out_of_range");
    endtask

    task automatic test_midperiod();
        logic [CH:0] e;
        int d1;
        int ed;
        ch_sel = 2'd1;
        wait_ps();
        dec_btn = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            d1 = ((j - 1) < P) ? DR : DR - ST;
            e[CH] = (j % P == 0);
            e[0]  = ((j - 1) % P) < (DR + ST);
            e[1]  = ((j - 1) % P) < d1;
            e[2]  = 1'b1;
            exp_q.push_back(e);
            duty_q.push_back((j <= P) ? DR : DR - ST);
        end
        for (int j = 1; j <= 20; j++) begin
            step();
            if (j == 8) dec_btn = 1'b0;
            e  = exp_q.pop_front();
            ed = duty_q.pop_front();
            checks++;
            if ({period_start, pwm_out} !== e || duty_of(1) !== ed) begin
                errors++;
                $display("FAIL midperiod j=%0d: {ps,pwm}=%b duty1=%0d want %b %0d",
                         j, {period_start, pwm_out}, duty_of(1), e, ed);
            end
        end
    endtask

    task automatic test_center();
        logic [CH:0] e;
        ch_sel = 2'd1;
        press(1'b0, 1'b1, 8);
        press(1'b1, 1'b0, 8);
        duty_q.push_back(DR + ST);
        duty_q.push_back(3);
        duty_q.push_back(P);
        wait_ps();
        step();
        check_duties("center_setup");
        wait_ps();
        repeat (3) step();
        mode = 1'b1;
        wait_ps();
        for (int j = 1; j <= 40; j++) begin
            e[CH] = (j % (2 * P) == 0);
            e[0]  = cc(j - 1) < (DR + ST);
            e[1]  = cc(j - 1) < 3;
            e[2]  = cc(j - 1) < P;
            exp_q.push_back(e);
        end
        check_stream("center");
    endtask

    task automatic test_reset_mid();
        repeat (13) step();
        mode = 1'b0;
        do_reset();
        checks++;
        if (period_start !== 1'b1 || pwm_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_state: ps=%b pwm=%b want 1 000",
                     period_start, pwm_out);
        end
        duty_q.push_back(DR);
        duty_q.push_back(DR);
        duty_q.push_back(DR);
        check_duties("reset_mid_duty");
        push_edge(DR, DR, DR, 20);
        check_stream("reset_mid_pattern");
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_hold();
        test_midperiod();
        test_center();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
